// File: rtl/iir_pkg.sv
// Shared definitions for the multichannel time-multiplexed biquad.
package iir_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_MAC   = 2'd1;
  localparam state_t ST_WRITE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam int MAC_STEPS = 5;
  // Guard bits so five full-scale products cannot wrap the accumulator.
  localparam int ACC_GUARD = 3;

  function automatic int acc_width(input int data_w, input int coeff_w);
    return data_w + coeff_w + ACC_GUARD;
  endfunction

endpackage

// File: rtl/iir_sat.sv
// Arithmetic right shift then clamp to the signed output range.
// Purely combinational, no handshake.
module iir_sat #(
  parameter int IN_WIDTH  = 37,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 14
) (
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout
);

  localparam logic signed [IN_WIDTH-1:0] MAX_V =
    {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH-1:0] MIN_V =
    {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [IN_WIDTH-1:0] shifted;

  assign shifted = din >>> SHIFT;

  always_comb begin
    if (shifted > MAX_V)
      dout = MAX_V[OUT_WIDTH-1:0];
    else if (shifted < MIN_V)
      dout = MIN_V[OUT_WIDTH-1:0];
    else
      dout = shifted[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/iir_biquad_mc.sv
// Direct-form-I biquad shared across CHANNELS with one multiplier; out_valid 6*CHANNELS+1
// cycles after a sample strobe. No backpressure: strobes arriving while busy are dropped and flagged.
module iir_biquad_mc
  import iir_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 18,
  parameter int COEFF_SCALE = 14,
  parameter int COUNT_BITS  = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [COUNT_BITS-1:0]          div,
  input  logic signed [COEFF_WIDTH-1:0]  A2,
  input  logic signed [COEFF_WIDTH-1:0]  A3,
  input  logic signed [COEFF_WIDTH-1:0]  B1,
  input  logic signed [COEFF_WIDTH-1:0]  B2,
  input  logic signed [COEFF_WIDTH-1:0]  B3,
  input  logic                           bypass,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in,
  output logic [CHANNELS*DATA_WIDTH-1:0] out,
  output logic                           out_valid,
  output logic                           overrun
);

  localparam int AW = acc_width(DATA_WIDTH, COEFF_WIDTH);
  localparam int PW = DATA_WIDTH + COEFF_WIDTH;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [COUNT_BITS-1:0]         count;
  logic                          strobe;
  state_t                        state;
  logic [CW-1:0]                 ch;
  logic [2:0]                    step;
  logic                          last_ch;
  logic signed [DATA_WIDTH-1:0]  x0 [CHANNELS];
  logic signed [DATA_WIDTH-1:0]  x1 [CHANNELS];
  logic signed [DATA_WIDTH-1:0]  x2 [CHANNELS];
  logic signed [DATA_WIDTH-1:0]  y0 [CHANNELS];
  logic signed [DATA_WIDTH-1:0]  y1 [CHANNELS];
  logic signed [AW-1:0]          acc;
  logic signed [COEFF_WIDTH-1:0] coef;
  logic signed [DATA_WIDTH-1:0]  samp;
  logic signed [PW-1:0]          prod;
  logic signed [AW-1:0]          prod_ext;
  logic signed [AW-1:0]          term;
  logic signed [AW-1:0]          acc_base;
  logic signed [DATA_WIDTH-1:0]  sat;

  assign strobe  = (div != '0) && (count == div - COUNT_BITS'(1));
  assign last_ch = (ch == CW'(CHANNELS - 1));

  always_comb begin
    coef = B1;
    samp = x0[ch];
    case (step)
      3'd1: begin coef = B2; samp = x1[ch]; end
      3'd2: begin coef = B3; samp = x2[ch]; end
      3'd3: begin coef = A2; samp = y0[ch]; end
      3'd4: begin coef = A3; samp = y1[ch]; end
      default: ;
    endcase
  end

  // Feedback terms are subtracted rather than negating A, which avoids overflow at the most negative coefficient.
  assign prod     = coef * samp;
  assign prod_ext = AW'(prod);
  assign term     = (step >= 3'd3) ? -prod_ext : prod_ext;
  assign acc_base = (step == 3'd0) ? '0 : acc;

  iir_sat #(
    .IN_WIDTH  (AW),
    .OUT_WIDTH (DATA_WIDTH),
    .SHIFT     (COEFF_SCALE)
  ) u_sat (
    .din  (acc),
    .dout (sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      state     <= ST_IDLE;
      ch        <= '0;
      step      <= '0;
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        x0[i] <= '0;
        x1[i] <= '0;
        x2[i] <= '0;
        y0[i] <= '0;
        y1[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (div == '0 || strobe)
        count <= '0;
      else
        count <= count + COUNT_BITS'(1);

      if (strobe && state != ST_IDLE)
        overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (strobe) begin
            for (int i = 0; i < CHANNELS; i++) begin
              x2[i] <= x1[i];
              x1[i] <= x0[i];
              x0[i] <= in[i*DATA_WIDTH +: DATA_WIDTH];
            end
            ch    <= '0;
            step  <= '0;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc <= acc_base + term;
          if (step == 3'(MAC_STEPS - 1)) begin
            step  <= '0;
            state <= ST_WRITE;
          end else begin
            step <= step + 3'd1;
          end
        end
        ST_WRITE: begin
          y1[ch] <= y0[ch];
          y0[ch] <= sat;
          if (last_ch) begin
            // Output lanes load on the edge into DONE so data and out_valid are visible together.
            for (int i = 0; i < CHANNELS; i++) begin
              if (bypass)
                out[i*DATA_WIDTH +: DATA_WIDTH] <= x0[i];
              else if (CW'(i) == ch)
                out[i*DATA_WIDTH +: DATA_WIDTH] <= sat;
              else
                out[i*DATA_WIDTH +: DATA_WIDTH] <= y0[i];
            end
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            ch    <= ch + CW'(1);
            state <= ST_MAC;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_mc.sv
// Directed-vector bench for iir_biquad_mc with hand-computed expected outputs.
module tb_iir_biquad_mc;

  localparam int CH = 2;
  localparam int DW = 16;
  localparam int CWID = 18;
  localparam int CB = 10;
  localparam int LIMIT = 200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [CB-1:0] div = 10'd20;
  logic signed [CWID-1:0] A2 = '0, A3 = '0, B1 = '0, B2 = '0, B3 = '0;
  logic bypass = 1'b0;
  logic signed [DW-1:0] in0 = '0, in1 = '0;
  logic [CH*DW-1:0] in_bus;
  logic [CH*DW-1:0] out_bus;
  logic out_valid;
  logic overrun;
  logic signed [DW-1:0] out0, out1;

  int errors = 0;
  int checks = 0;

  assign in_bus = {in1, in0};
  assign out0 = out_bus[DW-1:0];
  assign out1 = out_bus[2*DW-1:DW];

  always #5 clk = ~clk;

  iir_biquad_mc #(
    .CHANNELS(CH), .DATA_WIDTH(DW), .COEFF_WIDTH(CWID), .COEFF_SCALE(14), .COUNT_BITS(CB)
  ) dut (
    .clk(clk), .reset(reset), .div(div),
    .A2(A2), .A3(A3), .B1(B1), .B2(B2), .B3(B3),
    .bypass(bypass), .in(in_bus), .out(out_bus),
    .out_valid(out_valid), .overrun(overrun)
  );

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first cycle after reset deasserts.
  task automatic do_reset();
    reset = 1'b1;
    step_clk();
    step_clk();
    reset = 1'b0;
  endtask

  // Returns the number of clock edges until out_valid is seen.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      step_clk();
      n++;
    end while (!out_valid && n < LIMIT);
    if (!out_valid) begin
      errors++;
      checks++;
      $display("FAIL wait_valid: no out_valid within %0d cycles", LIMIT);
    end
  endtask

  task automatic set_lowpass();
    A2 = -18'sd18174; A3 = 18'sd6523;
    B1 = 18'sd1183;   B2 = 18'sd2367;  B3 = 18'sd1183;
  endtask

  task automatic test_reset();
    int pulses;
    div = 10'd20; set_lowpass(); in0 = 16'sd1000; in1 = -16'sd1000;
    do_reset();
    checks++; if (out_bus !== '0) begin errors++; $display("FAIL reset_out: got %h expected 0", out_bus); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    div = 10'd0;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 150; i++) begin
      step_clk();
      if (out_valid) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL div_zero: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_impulse();
    int n;
    div = 10'd20; set_lowpass(); in0 = 16'sd16384; in1 = 16'sd0;
    do_reset();
    wait_valid(n);
    in0 = 16'sd0;
    checks++; if (out0 !== 16'sd1183) begin errors++; $display("FAIL impulse_y0: got %0d expected 1183", out0); end
    checks++; if (out1 !== 16'sd0) begin errors++; $display("FAIL impulse_ch1_0: got %0d expected 0", out1); end
    wait_valid(n);
    checks++; if (out0 !== 16'sd3679) begin errors++; $display("FAIL impulse_y1: got %0d expected 3679", out0); end
    checks++; if (out1 !== 16'sd0) begin errors++; $display("FAIL impulse_ch1_1: got %0d expected 0", out1); end
    wait_valid(n);
    checks++; if (out0 !== 16'sd4792) begin errors++; $display("FAIL impulse_y2: got %0d expected 4792", out0); end
    checks++; if (out1 !== 16'sd0) begin errors++; $display("FAIL impulse_ch1_2: got %0d expected 0", out1); end
  endtask

  task automatic test_step();
    int n;
    int d;
    div = 10'd20; set_lowpass(); in0 = 16'sd10000; in1 = 16'sd0;
    do_reset();
    wait_valid(n);
    checks++; if (out0 !== 16'sd722) begin errors++; $display("FAIL step_y0: got %0d expected 722", out0); end
    wait_valid(n);
    checks++; if (out0 !== 16'sd2967) begin errors++; $display("FAIL step_y1: got %0d expected 2967", out0); end
    for (int k = 2; k < 40; k++) wait_valid(n);
    d = int'(out0) - 10000;
    checks++; if (d < -2 || d > 2) begin errors++; $display("FAIL step_settle: got %0d expected 10000+-2", out0); end
    checks++; if (out1 !== 16'sd0) begin errors++; $display("FAIL step_ch1: got %0d expected 0", out1); end
  endtask

  task automatic test_saturation();
    int n;
    div = 10'd20;
    A2 = '0; A3 = '0; B1 = 18'sd32767; B2 = '0; B3 = '0;
    in0 = 16'sd30000; in1 = -16'sd30000;
    do_reset();
    wait_valid(n);
    in0 = 16'sd1000; in1 = -16'sd1000;
    checks++; if (out0 !== 16'sd32767) begin errors++; $display("FAIL sat_pos: got %0d expected 32767", out0); end
    checks++; if (out1 !== -16'sd32768) begin errors++; $display("FAIL sat_neg: got %0d expected -32768", out1); end
    wait_valid(n);
    checks++; if (out0 !== 16'sd1999) begin errors++; $display("FAIL shift_pos: got %0d expected 1999", out0); end
    checks++; if (out1 !== -16'sd2000) begin errors++; $display("FAIL shift_neg: got %0d expected -2000", out1); end
  endtask

  task automatic test_timing();
    int n;
    div = 10'd20; set_lowpass(); in0 = 16'sd100; in1 = 16'sd200;
    do_reset();
    // Strobe lands div-1 edges into this window; out_valid 13 cycles later.
    wait_valid(n);
    checks++; if (n != 32) begin errors++; $display("FAIL first_latency: got %0d expected 32", n); end
    step_clk();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse: got %b expected 0", out_valid); end
    wait_valid(n);
    checks++; if (n != 19) begin errors++; $display("FAIL valid_period: got %0d expected 19", n); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL no_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_overrun();
    int n;
    div = 10'd5;
    A2 = '0; A3 = '0; B1 = 18'sd8192; B2 = 18'sd8192; B3 = '0;
    in0 = 16'sd4000; in1 = -16'sd2000;
    do_reset();
    wait_valid(n);
    checks++; if (n != 17) begin errors++; $display("FAIL ovr_latency: got %0d expected 17", n); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
    checks++; if (out0 !== 16'sd2000 || out1 !== -16'sd1000) begin
      errors++; $display("FAIL ovr_first: got %0d/%0d expected 2000/-1000", out0, out1); end
    for (int k = 0; k < 2; k++) begin
      wait_valid(n);
      checks++; if (n != 15) begin errors++; $display("FAIL ovr_period: got %0d expected 15", n); end
      checks++; if (out0 !== 16'sd4000 || out1 !== -16'sd2000) begin
        errors++; $display("FAIL ovr_data: got %0d/%0d expected 4000/-2000", out0, out1); end
    end
  endtask

  task automatic test_reset_mid_mac();
    int n;
    div = 10'd20; set_lowpass(); in0 = 16'sd16384; in1 = 16'sd500;
    do_reset();
    wait_valid(n);
    // Next strobe is 7 cycles after this out_valid; reset lands 4 cycles into its MAC.
    repeat (11) step_clk();
    reset = 1'b1;
    step_clk();
    checks++; if (out_bus !== '0) begin errors++; $display("FAIL midreset_out: got %h expected 0", out_bus); end
    checks++; if (out_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL midreset_flags: got %b/%b expected 0/0", out_valid, overrun); end
    reset = 1'b0;
    wait_valid(n);
    checks++; if (n != 32) begin errors++; $display("FAIL midreset_latency: got %0d expected 32", n); end
    checks++; if (out0 !== 16'sd1183) begin errors++; $display("FAIL midreset_ch0: got %0d expected 1183", out0); end
    checks++; if (out1 !== 16'sd36) begin errors++; $display("FAIL midreset_ch1: got %0d expected 36", out1); end
  endtask

  task automatic test_bypass();
    int n;
    int d;
    div = 10'd20; set_lowpass(); in0 = 16'sd0; in1 = -16'sd1234; bypass = 1'b1;
    do_reset();
    wait_valid(n);
    checks++; if (out1 !== -16'sd1234) begin errors++; $display("FAIL bypass_ch1: got %0d expected -1234", out1); end
    checks++; if (out0 !== 16'sd0) begin errors++; $display("FAIL bypass_ch0: got %0d expected 0", out0); end
    for (int k = 0; k < 40; k++) wait_valid(n);
    bypass = 1'b0;
    wait_valid(n);
    d = int'(out1) + 1234;
    checks++; if (d < -4 || d > 4) begin errors++; $display("FAIL bypass_release: got %0d expected -1234+-4", out1); end
    checks++; if (out0 !== 16'sd0) begin errors++; $display("FAIL bypass_release_ch0: got %0d expected 0", out0); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_step();
    test_saturation();
    test_timing();
    test_overrun();
    test_reset_mid_mac();
    test_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
